// File: rtl/pipo_pkg.sv
// Shared defaults and the default data word type for the parallel-in parallel-out register.
package pipo_pkg;

    localparam int unsigned PIPO_DEFAULT_WIDTH  = 4;
    localparam int unsigned PIPO_DEFAULT_STAGES = 1;

    typedef logic [PIPO_DEFAULT_WIDTH-1:0] pipo_word_t;

endpackage

// File: rtl/pipo_stage.sv
// Single WIDTH-bit register stage with synchronous active-low reset and a hold enable.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int unsigned           WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over enable so a cleared chain never holds stale data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipo_register.sv
// Parallel-in parallel-out register chain of STAGES stages (latency = STAGES cycles).
// Define PIPO_LOAD_EN to add a `load` input that gates advancement of the whole chain.
module pipo_register
    import pipo_pkg::*;
#(
    parameter int unsigned      WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter int unsigned      STAGES      = PIPO_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef PIPO_LOAD_EN
    input  logic             load,
`endif
    input  logic [WIDTH-1:0] pdi,
    output logic [WIDTH-1:0] pdo
);

    logic             advance;
    logic [WIDTH-1:0] chain [STAGES+1];

`ifdef PIPO_LOAD_EN
    assign advance = load;
`else
    assign advance = 1'b1;
`endif

    assign chain[0] = pdi;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipo_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (advance),
            .d       (chain[k]),
            .q       (chain[k+1])
        );
    end

    // Output comes straight from the last register; no path from pdi.
    assign pdo = chain[STAGES];

endmodule

// File: tb/tb_pipo_register.sv
// Directed self-checking bench for pipo_register with STAGES=1 and STAGES=3 instances.
module tb_pipo_register;
    import pipo_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       load;
    pipo_word_t pdi;
    pipo_word_t pdo1;
    pipo_word_t pdo3;

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipo_register #(
        .WIDTH  (4),
        .STAGES (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef PIPO_LOAD_EN
        .load    (load),
`endif
        .pdi     (pdi),
        .pdo     (pdo1)
    );

    pipo_register #(
        .WIDTH  (4),
        .STAGES (3)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef PIPO_LOAD_EN
        .load    (load),
`endif
        .pdi     (pdi),
        .pdo     (pdo3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        load    = 1'b1;
        pdi     = 4'hF;

        // Reset with pdi all-ones: pdi must be ignored.
        tick();
        check("reset_edge1_s1", pdo1, 4'h0);
        check("reset_edge1_s3", pdo3, 4'h0);
        tick();
        check("reset_edge2_s1", pdo1, 4'h0);
        check("reset_edge2_s3", pdo3, 4'h0);

        // Capture and hold.
        reset_n = 1'b1;
        pdi     = 4'b1011;
        tick();
        check("capture", pdo1, 4'b1011);
        tick();
        check("hold", pdo1, 4'b1011);

        // Reset dropped mid-cycle takes effect only at the next edge.
        #3;
        reset_n = 1'b0;
        #2;
        check("sync_reset_before_edge", pdo1, 4'b1011);
        tick();
        check("sync_reset_after_edge", pdo1, 4'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_held_s1", pdo1, 4'h0);
            check("reset_held_s3", pdo3, 4'h0);
        end

        // Back-to-back words.
        reset_n = 1'b1;
        pdi = 4'h1; tick(); check("b2b_1", pdo1, 4'h1); check("b2b_s3_a", pdo3, 4'h0);
        pdi = 4'h2; tick(); check("b2b_2", pdo1, 4'h2); check("b2b_s3_b", pdo3, 4'h0);
        pdi = 4'hA; tick(); check("b2b_A", pdo1, 4'hA); check("b2b_s3_c", pdo3, 4'h1);
        pdi = 4'hF; tick(); check("b2b_F", pdo1, 4'hF); check("b2b_s3_d", pdo3, 4'h2);

        // Flush the 3-stage chain with zeros.
        pdi = 4'h0;
        tick(); tick(); tick();
        check("flush_s3", pdo3, 4'h0);

        // Depth: a single word appears exactly two edges after capture.
        pdi = 4'h5;
        tick();
        check("depth_N", pdo3, 4'h0);
        pdi = 4'h0;
        tick();
        check("depth_N1", pdo3, 4'h0);
        tick();
        check("depth_N2", pdo3, 4'h5);
        tick();
        check("depth_N3", pdo3, 4'h0);

        // Reset while the word is in flight: it must never emerge.
        pdi = 4'h5;
        tick();
        pdi     = 4'h0;
        reset_n = 1'b0;
        tick();
        check("inflight_reset", pdo3, 4'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("inflight_cleared", pdo3, 4'h0);
        end

`ifdef PIPO_LOAD_EN
        pdi = 4'h3;
        tick();
        check("load_prime", pdo1, 4'h3);
        load = 1'b0;
        pdi  = 4'h9;
        tick();
        check("load0_hold_a", pdo1, 4'h3);
        tick();
        check("load0_hold_b", pdo1, 4'h3);
        load = 1'b1;
        tick();
        check("load1_capture", pdo1, 4'h9);
        reset_n = 1'b0;
        tick();
        check("reset_over_load", pdo1, 4'h0);
        reset_n = 1'b1;
        load    = 1'b0;
        reset_n = 1'b0;
        tick();
        check("reset_load0", pdo1, 4'h0);
        reset_n = 1'b1;
        load    = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
